// File: rtl/mul_sequencer.sv
// Iterative signed shift-add multiplier sequencer for the EX stage.
// Holds the pipeline while one multiplier bit is consumed per cycle,
// then presents the 2*WIDTH-bit signed product for a single cycle.
module mul_sequencer #(
   parameter int unsigned WIDTH    = 32,
   parameter logic [3:0]  MUL_CODE = 4'b1011
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [3:0]       ALUSel,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             stall,
   output logic             result_valid,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e             state_q;
   logic [CW-1:0]      count_q;
   logic [WIDTH:0]     mcand_q;
   logic [WIDTH:0]     mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               neg_q;

   logic               req;
   logic [WIDTH:0]     mag_a;
   logic [WIDTH:0]     mag_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] product;

   assign req = ex_valid & (ALUSel == MUL_CODE);

   // Operand magnitudes are one bit wider so the most negative value has a magnitude.
   always_comb begin
      mag_a = srcA[WIDTH-1] ? -{1'b1, srcA} : {1'b0, srcA};
      mag_b = srcB[WIDTH-1] ? -{1'b1, srcB} : {1'b0, srcB};
   end

   // One shift-add step: conditionally add the multiplicand to the upper half, keep the
   // carry, then shift the whole accumulator right by one.
   always_comb begin
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? mcand_q : '0);
      acc_next = {sum, acc_q[WIDTH-1:1]};
      product  = neg_q ? -acc_next : acc_next;
   end

   // Stall covers the request cycle and every busy cycle; a flush or reset releases it at once.
   always_comb begin
      stall = 1'b0;
      if (!reset) begin
         case (state_q)
            StIdle:  stall = req & ~flush;
            StBusy:  stall = ~flush;
            default: stall = 1'b0;
         endcase
      end
   end

   // Sequencer state, datapath registers and registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         count_q      <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         acc_q        <= '0;
         neg_q        <= 1'b0;
         result_valid <= 1'b0;
         result_hi    <= '0;
         result_lo    <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!flush && req) begin
                  mcand_q  <= mag_a;
                  mplier_q <= mag_b;
                  neg_q    <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                  acc_q    <= '0;
                  count_q  <= '0;
                  state_q  <= StBusy;
               end
            end
            StBusy: begin
               if (flush) begin
                  state_q <= StIdle;
               end else begin
                  acc_q    <= acc_next;
                  mplier_q <= mplier_q >> 1;
                  count_q  <= count_q + CW'(1);
                  if (count_q == CW'(WIDTH - 1)) begin
                     state_q                  <= StDone;
                     result_valid             <= 1'b1;
                     {result_hi, result_lo}   <= product;
                  end
               end
            end
            StDone: begin
               // Any request still visible here is the retiring multiply.
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
